// File: rtl/multiword_add_seq_pkg.sv
// Shared types and sizing helpers for the multi-word add/subtract sequencer.
package mwadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W_DEF    = 32;
  localparam int NUM_WORDS_DEF = 4;

  // Word index counter width; never narrower than one bit so NUM_WORDS=1 still has a counter.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(NUM_WORDS_DEF);

endpackage

// File: rtl/multiword_add_seq_prefix_adder_w.sv
// WORD_W-bit Kogge-Stone adder with carry-in/carry-out, built from the pg/fco/sum cells.
// Purely combinational; carry-in is folded into the bit-0 generate term.

module pg_block (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);
  assign g = a & b;
  assign p = a ^ b;
endmodule

module fco_block (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

module sum_block (
  input  logic p,
  input  logic c,
  output logic s
);
  assign s = p ^ c;
endmodule

module prefix_adder_w #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int LV = (WORD_W > 1) ? $clog2(WORD_W) : 0;

  logic [WORD_W-1:0]        g0;
  logic [WORD_W-1:0]        p0;
  logic [LV:0][WORD_W-1:0]  gl;
  logic [LV:0][WORD_W-1:0]  pl;
  logic [WORD_W-1:0]        c;
  logic                     unused_p_top;

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    pg_block u_pg (.a(a[i]), .b(b[i]), .g(g0[i]), .p(p0[i]));
    if (i == 0) begin : g_cin
      assign gl[0][i] = g0[i] | (p0[i] & cin);
    end else begin : g_nocin
      assign gl[0][i] = g0[i];
    end
    assign pl[0][i] = p0[i];
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    for (genvar i = 0; i < WORD_W; i++) begin : g_node
      if (i >= (1 << l)) begin : g_cell
        fco_block u_fco (
          .g_hi (gl[l][i]),
          .p_hi (pl[l][i]),
          .g_lo (gl[l][i-(1<<l)]),
          .p_lo (pl[l][i-(1<<l)]),
          .g    (gl[l+1][i]),
          .p    (pl[l+1][i])
        );
      end else begin : g_pass
        assign gl[l+1][i] = gl[l][i];
        assign pl[l+1][i] = pl[l][i];
      end
    end
  end

  // Group propagate of the final level has no consumer once every prefix reaches bit 0.
  assign unused_p_top = ^pl[LV];

  for (genvar i = 0; i < WORD_W; i++) begin : g_sum
    if (i == 0) begin : g_c0
      assign c[i] = cin;
    end else begin : g_ci
      assign c[i] = gl[LV][i-1];
    end
    sum_block u_sum (.p(p0[i]), .c(c[i]), .s(sum[i]));
  end

  assign cout = gl[LV][WORD_W-1];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract sequenced over one shared WORD_W adder, LS word first; result valid NUM_WORDS edges after accept.
// No overlap: in_ready only in IDLE; DONE holds the result until out_ready.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_a,
  input  logic [WORD_W*NUM_WORDS-1:0] in_b,
  input  logic                        in_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_ovf,
  output logic                        busy
);

  localparam int TOT = WORD_W * NUM_WORDS;
  localparam int IW  = (NUM_WORDS == NUM_WORDS_DEF) ? IDX_W : idx_width(NUM_WORDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TOT-1:0]    a_q;
  logic [TOT-1:0]    b_q;
  logic              carry_q;
  logic [IW-1:0]     idx_q;
  logic [WORD_W-1:0] a_w;
  logic [WORD_W-1:0] b_w;
  logic [WORD_W-1:0] s_w;
  logic              c_w;
  logic              accept;
  logic              step;
  logic              last;

  assign a_w = a_q[idx_q*WORD_W +: WORD_W];
  assign b_w = b_q[idx_q*WORD_W +: WORD_W];

  prefix_adder_w #(.WORD_W(WORD_W)) u_add (
    .a    (a_w),
    .b    (b_w),
    .cin  (carry_q),
    .sum  (s_w),
    .cout (c_w)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        last = (idx_q == LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B once here and seed the carry with in_sub.
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub;
      idx_q   <= '0;
    end else if (step) begin
      out_sum[idx_q*WORD_W +: WORD_W] <= s_w;
      carry_q <= c_w;
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        out_cout <= c_w;
        out_ovf  <= (a_w[WORD_W-1] == b_w[WORD_W-1]) & (s_w[WORD_W-1] != a_w[WORD_W-1]);
      end
    end
  end

endmodule
